// File: rtl/router_fsm_if.sv
// Bundle of the source handshake, FIFO status and register-stage control
// signals exchanged between the router control FSM and its neighbours.
interface router_fsm_if;
   logic       pktvalid;
   logic [1:0] din;
   logic       fifofull;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       lowpktvalid;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic       write_enb_reg;
   logic       busy;

   modport slave (
      input  pktvalid, din, fifofull,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, lowpktvalid,
      output detect_add, lfd_state, ld_state, laf_state, full_state,
      output rst_int_reg, write_enb_reg, busy
   );

   modport master (
      output pktvalid, din, fifofull,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, lowpktvalid,
      input  detect_add, lfd_state, ld_state, laf_state, full_state,
      input  rst_int_reg, write_enb_reg, busy
   );
endinterface

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 router: decodes the header address and sequences
// the register stage through header, payload, full-stall and parity phases.
//
//   state | meaning
//   DA    | decode address, waiting for a header byte
//   LFD   | load first data (header) into the addressed FIFO
//   LD    | load payload bytes
//   FFS   | addressed FIFO full, stall the source
//   LAF   | resume loading after a full stall
//   LP    | load the parity byte
//   CPE   | check parity error, one-cycle internal register reset
//   WTE   | wait until the addressed FIFO drains
module router_fsm (
   input  logic         clk,
   input  logic         rst,
   router_fsm_if.slave  bus
);
   typedef enum logic [2:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE} state_e;

   state_e     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic [3:0] empty_v;
   logic [3:0] soft_v;

   // Bit 3 pads the per-port vectors so a 2-bit index never leaves range.
   assign empty_v = {1'b0, bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
   assign soft_v  = {1'b0, bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DA;
         addr_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      case (state_q)
         DA: begin
            if (bus.pktvalid && bus.din != 2'b11) begin
               addr_d  = bus.din;
               state_d = empty_v[bus.din] ? LFD : WTE;
            end
         end
         LFD: state_d = LD;
         LD: begin
            if (bus.fifofull)       state_d = FFS;
            else if (!bus.pktvalid) state_d = LP;
         end
         FFS: if (!bus.fifofull) state_d = LAF;
         LAF: begin
            if (bus.parity_done)      state_d = DA;
            else if (bus.lowpktvalid) state_d = LP;
            else                      state_d = LD;
         end
         LP:  state_d = CPE;
         CPE: state_d = bus.fifofull ? FFS : DA;
         WTE: if (empty_v[addr_q]) state_d = LFD;
         default: state_d = DA;
      endcase
      // A timeout on the FIFO being written abandons the packet.
      if (state_q != DA && soft_v[addr_q]) state_d = DA;
   end

   assign bus.detect_add    = (state_q == DA);
   assign bus.lfd_state     = (state_q == LFD);
   assign bus.ld_state      = (state_q == LD);
   assign bus.laf_state     = (state_q == LAF);
   assign bus.full_state    = (state_q == FFS);
   assign bus.rst_int_reg   = (state_q == CPE);
   assign bus.write_enb_reg = (state_q == LD) || (state_q == LP) || (state_q == LAF);
   assign bus.busy          = (state_q != DA) && (state_q != LD);
endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: table vectors, directed corner sequences and a
// randomized run, all compared against a packet-level reference model.
module tb_router_fsm;
   logic clk = 1'b0;
   logic rst = 1'b0;
   router_fsm_if bus ();

   router_fsm dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}
   localparam logic [7:0] O_DA  = 8'b1000_0000;
   localparam logic [7:0] O_LFD = 8'b0100_0001;
   localparam logic [7:0] O_LD  = 8'b0010_0010;
   localparam logic [7:0] O_FFS = 8'b0000_1001;
   localparam logic [7:0] O_LAF = 8'b0001_0011;
   localparam logic [7:0] O_LP  = 8'b0000_0011;
   localparam logic [7:0] O_CPE = 8'b0000_0101;
   localparam logic [7:0] O_WTE = 8'b0000_0001;

   localparam int M_DA = 0, M_LFD = 1, M_LD = 2, M_FFS = 3;
   localparam int M_LAF = 4, M_LP = 5, M_CPE = 6, M_WTE = 7;

   logic [7:0] m_outs [8];
   int         m_st;
   int         m_addr;
   int         total = 0;
   int         bad   = 0;

   typedef struct {
      logic       pv;
      logic [1:0] din;
      logic [2:0] emp;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [9];

   function automatic logic [7:0] outs();
      return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Packet-level view: where is the current packet after this byte?
   task automatic model_next(input logic pv, input logic [1:0] din, input logic ff,
                             input logic [2:0] emp, input logic [2:0] sr,
                             input logic pd, input logic lpv);
      int nx;
      nx = m_st;
      if (m_st == M_DA) begin
         if (pv && din != 2'b11) begin
            m_addr = int'(din);
            nx = emp[m_addr] ? M_LFD : M_WTE;
         end
      end else if (sr[m_addr]) begin
         nx = M_DA;
      end else begin
         case (m_st)
            M_LFD: nx = M_LD;
            M_LD:  nx = ff ? M_FFS : (pv ? M_LD : M_LP);
            M_FFS: nx = ff ? M_FFS : M_LAF;
            M_LAF: nx = pd ? M_DA : (lpv ? M_LP : M_LD);
            M_LP:  nx = M_CPE;
            M_CPE: nx = ff ? M_FFS : M_DA;
            M_WTE: nx = emp[m_addr] ? M_LFD : M_WTE;
            default: nx = M_DA;
         endcase
      end
      m_st = nx;
   endtask

   task automatic step(input logic pv, input logic [1:0] din, input logic ff,
                       input logic [2:0] emp, input logic [2:0] sr,
                       input logic pd, input logic lpv);
      bus.pktvalid     = pv;
      bus.din          = din;
      bus.fifofull     = ff;
      bus.fifo_empty_0 = emp[0];
      bus.fifo_empty_1 = emp[1];
      bus.fifo_empty_2 = emp[2];
      bus.soft_reset_0 = sr[0];
      bus.soft_reset_1 = sr[1];
      bus.soft_reset_2 = sr[2];
      bus.parity_done  = pd;
      bus.lowpktvalid  = lpv;
      model_next(pv, din, ff, emp, sr, pd, lpv);
      @(posedge clk);
      #1;
      check("model", outs(), m_outs[m_st]);
   endtask

   initial begin
      m_outs[M_DA]  = O_DA;  m_outs[M_LFD] = O_LFD; m_outs[M_LD]  = O_LD;
      m_outs[M_FFS] = O_FFS; m_outs[M_LAF] = O_LAF; m_outs[M_LP]  = O_LP;
      m_outs[M_CPE] = O_CPE; m_outs[M_WTE] = O_WTE;
      m_st = M_DA;
      m_addr = 0;

      vecs[0] = '{1'b1, 2'b01, 3'b111, O_LFD};
      vecs[1] = '{1'b1, 2'b00, 3'b111, O_LD};
      vecs[2] = '{1'b1, 2'b10, 3'b111, O_LD};
      vecs[3] = '{1'b1, 2'b01, 3'b111, O_LD};
      vecs[4] = '{1'b0, 2'b00, 3'b111, O_LP};
      vecs[5] = '{1'b0, 2'b00, 3'b111, O_CPE};
      vecs[6] = '{1'b0, 2'b00, 3'b111, O_DA};
      vecs[7] = '{1'b1, 2'b11, 3'b111, O_DA};
      vecs[8] = '{1'b0, 2'b01, 3'b111, O_DA};

      bus.pktvalid = 0; bus.din = 0; bus.fifofull = 0;
      bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
      bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
      bus.parity_done = 0; bus.lowpktvalid = 0;

      #12;
      check("reset", outs(), O_DA);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) begin
         step(vecs[i].pv, vecs[i].din, 1'b0, vecs[i].emp, 3'b000, 1'b0, 1'b0);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // FIFO 2 occupied: wait five cycles, then it drains
      step(1, 2'b10, 0, 3'b011, 3'b000, 0, 0);
      check("wte_entry", outs(), O_WTE);
      for (int i = 0; i < 4; i++) begin
         step(1, 2'b10, 0, 3'b011, 3'b000, 0, 0);
         check("wte_hold", outs(), O_WTE);
      end
      step(1, 2'b10, 0, 3'b111, 3'b000, 0, 0);
      check("wte_to_lfd", outs(), O_LFD);
      step(1, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      step(0, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      step(0, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      step(0, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      check("wte_pkt_end", outs(), O_DA);

      // Full stall on FIFO 0, then soft resets of wrong and right port
      step(1, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      step(1, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      check("ffs_ld", outs(), O_LD);
      for (int i = 0; i < 3; i++) begin
         step(1, 2'b00, 1, 3'b111, 3'b000, 0, 0);
         check("ffs_hold", outs(), O_FFS);
      end
      step(1, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      check("laf", outs(), O_LAF);
      step(1, 2'b00, 0, 3'b111, 3'b000, 0, 0);
      check("laf_to_ld", outs(), O_LD);
      step(1, 2'b00, 1, 3'b111, 3'b000, 0, 0);
      check("ffs_again", outs(), O_FFS);
      step(1, 2'b00, 1, 3'b111, 3'b010, 0, 0);
      check("soft_other", outs(), O_FFS);
      step(1, 2'b00, 1, 3'b111, 3'b001, 0, 0);
      check("soft_own", outs(), O_DA);

      // Asynchronous reset in the middle of a packet
      step(1, 2'b01, 0, 3'b111, 3'b000, 0, 0);
      step(1, 2'b01, 0, 3'b111, 3'b000, 0, 0);
      check("pre_async_ld", outs(), O_LD);
      #2;
      rst = 1'b0;
      m_st = M_DA;
      m_addr = 0;
      #1;
      check("async_rst", outs(), O_DA);
      @(negedge clk);
      rst = 1'b1;
      step(1, 2'b00, 0, 3'b001, 3'b000, 0, 0);
      check("post_rst_lfd", outs(), O_LFD);

      for (int i = 0; i < 3000; i++) begin
         logic [2:0] sr;
         sr[0] = ($urandom_range(0, 19) == 0);
         sr[1] = ($urandom_range(0, 19) == 0);
         sr[2] = ($urandom_range(0, 19) == 0);
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), sr,
              $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/router_fsm.md
# router_fsm

Control state machine for the 1x3 router. It decodes the 2-bit destination address in each packet header and sequences the router's register stage through header load, payload load, FIFO-full stall and parity check. It also drives `busy` back to the packet source. It sits between the input port, the three output FIFOs and the register stage, whose control inputs it generates.

## Interface
- Parameters: none; port count fixed at 3, address width fixed at 2.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- pktvalid  in  1  source byte valid; deasserts after last payload byte, parity byte follows
- din  in  2  din[1:0] of source byte; destination address, sampled in DECODE_ADDRESS only
- fifofull  in  1  full flag of currently addressed FIFO (muxed outside this block)
- fifo_empty_0/1/2  in  1 each  empty flags of output FIFOs
- soft_reset_0/1/2  in  1 each  per-FIFO read-timeout reset
- parity_done  in  1  from register stage
- lowpktvalid  in  1  from register stage
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  register-stage controls
- write_enb_reg  out  1  write strobe to addressed FIFO
- busy  out  1  source must hold current byte while high

## Operation
- Eight states: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE). State register only; all outputs are combinational decode of state (Moore).
- Address latch `addr[1:0]` loads din in DA when pktvalid && din != 2'b11; holds otherwise.
- DA: pktvalid && din==k (k=0..2) && fifo_empty_k -> LFD; pktvalid && din==k && !fifo_empty_k -> WTE; din==2'b11 or !pktvalid -> DA.
- LFD -> LD unconditionally.
- LD: fifofull -> FFS; else !pktvalid -> LP; else LD.
- FFS: !fifofull -> LAF; else FFS.
- LAF: parity_done -> DA; else lowpktvalid -> LP; else LD.
- LP -> CPE unconditionally.
- CPE: fifofull -> FFS; else DA.
- WTE: fifo_empty_[addr] -> LFD; else WTE.
- Soft reset: soft_reset_k with addr==k in any state other than DA forces next state DA. This overrides every other transition. soft_reset_j with j != addr is ignored.
- Output decode:
  - detect_add = DA
  - lfd_state = LFD
  - ld_state = LD
  - laf_state = LAF
  - full_state = FFS
  - rst_int_reg = CPE
  - write_enb_reg = LD | LP | LAF
  - busy = LFD | FFS | LAF | LP | CPE | WTE; low in DA and LD.

## Timing
- Reset (rst low, async): state=DA, addr=2'b00. Outputs: detect_add=1, all other outputs 0.
- Release of rst is sampled on the next rising edge; the first transition can occur on that edge.
- Header-to-LFD latency: 1 cycle when the target FIFO is empty. Header-to-LD latency: 2 cycles.
- Parity byte timing:
  - pktvalid low in LD -> LP next cycle; write_enb_reg stays high there so the parity byte is written.
  - CPE lasts exactly 1 cycle (rst_int_reg pulse).
- FIFO full timing:
  - fifofull in LD -> FFS next cycle; write_enb_reg drops in FFS; busy rises.
  - Minimum full stall is FFS(1) + LAF(1).
- Simultaneous events:
  - Soft reset coincident with fifofull or pktvalid drop -> DA.
  - In DA with fifo_empty_k toggling, the value sampled at the edge decides LFD vs WTE.
- Mid-packet rst assertion: immediate return to DA regardless of state.

## Test plan
- Empty FIFO 1, header din=2'b01 with pktvalid, then 3 payload bytes, then pktvalid low -> required state sequence:
  - DA, LFD, LD, LD, LD, LP, CPE, DA
  - rst_int_reg high exactly 1 cycle
  - busy high in LFD/LP/CPE only.
- fifo_empty_2=0, header din=2'b10 -> WTE with busy=1, write_enb_reg=0. Raise fifo_empty_2 after 5 cycles -> LFD on the next edge.
- fifofull high during LD for 3 cycles:
  - FFS held 3 cycles (full_state=1, write_enb_reg=0).
  - Then LAF; with parity_done=0, lowpktvalid=0 -> LD.
- Header din=2'b11 with pktvalid -> stays DA, addr unchanged, busy=0.
- Packet to FIFO 0 stuck in FFS:
  - soft_reset_1 pulse -> no effect.
  - soft_reset_0 pulse -> DA next cycle, detect_add=1.
- rst low asynchronously mid-LD (between edges) -> outputs return to reset values immediately. After release, the next header din=2'b00 with fifo_empty_0=1 -> LFD after one edge.
